dual_port_bram_fifo_ctrl: RTL and testbench
===========================================

Name: dual_port_bram_fifo_ctrl

Overview:
Synchronous first-word-fall-through FIFO controller that drives an external dual_port_bram instance. Port A of the BRAM is used only for writes and port B only for reads. The controller is the master of both BRAM ports. It presents valid/ready push and pop streams to the client and hides the BRAM's one-cycle registered read latency behind a 2-entry output skid stage. It also guarantees that port B never reads an address in the same cycle port A writes it.

Parameters:
p_ADDRESS_WIDTH, 4, BRAM address width; memory depth D = 2**p_ADDRESS_WIDTH
p_DATA_WIDTH, 8, data word width

Ports:
i_CLK  in  1  clock; all logic on rising edge
i_RESET_N  in  1  synchronous active-low reset
i_PUSH_VALID  in  1  client offers i_PUSH_DATA
o_PUSH_READY  out  1  controller can accept a word
i_PUSH_DATA  in  p_DATA_WIDTH  write word
o_POP_VALID  out  1  o_POP_DATA holds the FIFO head
i_POP_READY  in  1  client consumes the head
o_POP_DATA  out  p_DATA_WIDTH  FIFO head word
o_WRITE_ENABLE_A  out  1  to BRAM i_WRITE_ENABLE_A
o_WRITE_ADDRESS_A  out  p_ADDRESS_WIDTH  to BRAM i_WRITE_ADDRESS_A
o_WRITE_DATA_A  out  p_DATA_WIDTH  to BRAM i_WRITE_DATA_A
o_READ_ENABLE_B  out  1  to BRAM i_READ_ENABLE_B
o_READ_ADDRESS_B  out  p_ADDRESS_WIDTH  to BRAM i_READ_ADDRESS_B
i_READ_DATA_B  in  p_DATA_WIDTH  from BRAM o_READ_DATA_B; valid the cycle after o_READ_ENABLE_B, zero otherwise
o_COUNT  out  p_ADDRESS_WIDTH+2  total words held: memory + in-flight + output stage (max D+2)

Behaviour:
- Reset: i_RESET_N=0 sampled at the edge clears all state. This applies equally mid-operation; all contents are discarded. Cleared state: write pointer r_WPTR=0, read pointer r_RPTR=0, r_MEM_WORDS=0, r_INFLIGHT=0, output stage count r_OUT_COUNT=0, output data registers=0. While i_RESET_N=0, o_WRITE_ENABLE_A=0 and o_READ_ENABLE_B=0.
- Outputs after reset: o_POP_VALID=0, o_POP_DATA=0, o_COUNT=0, o_PUSH_READY=1.
- Push fire: push = i_PUSH_VALID & o_PUSH_READY. o_PUSH_READY = (r_MEM_WORDS < D). It is registered-state only, with no combinational path from i_POP_READY.
- Write port: o_WRITE_ENABLE_A = push. o_WRITE_ADDRESS_A = r_WPTR. o_WRITE_DATA_A = i_PUSH_DATA. On push, r_WPTR increments mod D (wraps D-1 -> 0).
- Pop fire: pop = o_POP_VALID & i_POP_READY. o_POP_VALID = (r_OUT_COUNT != 0). o_POP_DATA = head output register, or 0 when empty.
- Read issue: issue = (r_MEM_WORDS != 0) & ((r_OUT_COUNT + r_INFLIGHT - pop) < 2). o_READ_ENABLE_B = issue and o_READ_ADDRESS_B = r_RPTR, both combinational. On issue, r_RPTR increments mod D.
- Read/write separation: a word written at edge t is counted in r_MEM_WORDS only after edge t, so it is readable from cycle t+1. Port B therefore never reads an address being written that cycle.
  - When r_MEM_WORDS = D, push is blocked.
  - The address collision that remains carries o_WRITE_ENABLE_A=0, so it is harmless.
- Memory count: r_MEM_WORDS <= r_MEM_WORDS + push - issue. Simultaneous push and issue leaves it unchanged.
- In-flight: r_INFLIGHT <= issue. When r_INFLIGHT=1, i_READ_DATA_B is captured at the end of that cycle into the output stage tail. Space is guaranteed by the issue rule.
- Output stage: 2-entry register FIFO. r_OUT_COUNT <= r_OUT_COUNT + r_INFLIGHT - pop. On pop, entry 1 shifts to the head. A capture coinciding with a pop fills the new tail slot.
- o_COUNT = r_MEM_WORDS + r_INFLIGHT + r_OUT_COUNT, registered.
- Latency, empty FIFO: push at cycle t; write lands at edge end of t; issue in t+1; data captured end of t+2; o_POP_VALID=1 in cycle t+3.
- Throughput: sustains 1 push and 1 pop per cycle indefinitely. The steady state is r_OUT_COUNT=1, r_INFLIGHT=1.
- Full: with no pops, D+2 words are accepted (D in memory, 2 in the output stage); o_PUSH_READY then drops.
- Empty: pop is not possible because o_POP_VALID=0; i_POP_READY is ignored.

Test Plan:
- Reset check: hold i_RESET_N=0 for 2 cycles, then release -> o_POP_VALID=0, o_COUNT=0, o_PUSH_READY=1, both BRAM enables 0.
- Single word: push 0xA5 at cycle t into an empty FIFO -> o_READ_ENABLE_B=1 with address 0 in t+1; o_POP_VALID=1 with o_POP_DATA=0xA5 in t+3; pop -> o_COUNT returns to 0.
- Fill: push 0x01..0x20 with i_POP_READY=0 (D=16) -> 18 words accepted; o_PUSH_READY=0 after the 18th; o_COUNT=18. Then pop all -> order 0x01..0x12; o_PUSH_READY reasserts one cycle after the first freeing issue.
- Streaming: continuous push and pop of 40 incrementing words -> 1 word/cycle after the 3-cycle fill, no gaps, pointers wrap past 15 with no data corruption.
- Backpressure: random i_POP_READY (50%) with random push for 500 cycles vs a scoreboard model -> exact order match; o_WRITE_ADDRESS_A never equals o_READ_ADDRESS_B while o_WRITE_ENABLE_A=1 and o_READ_ENABLE_B=1.
- Reset mid-operation: with 10 words stored, pulse i_RESET_N=0 for 1 cycle -> o_COUNT=0, o_POP_VALID=0 next cycle; next pushed word 0x77 pops first.

Source files
------------

// File: rtl/dual_port_bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller mastering an external dual-port BRAM:
// port A writes, port B reads, with a 2-entry output stage hiding read latency.
module dual_port_bram_fifo_ctrl #(
  parameter int p_ADDRESS_WIDTH = 4,
  parameter int p_DATA_WIDTH    = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET_N,
  input  logic                       i_PUSH_VALID,
  output logic                       o_PUSH_READY,
  input  logic [p_DATA_WIDTH-1:0]    i_PUSH_DATA,
  output logic                       o_POP_VALID,
  input  logic                       i_POP_READY,
  output logic [p_DATA_WIDTH-1:0]    o_POP_DATA,
  output logic                       o_WRITE_ENABLE_A,
  output logic [p_ADDRESS_WIDTH-1:0] o_WRITE_ADDRESS_A,
  output logic [p_DATA_WIDTH-1:0]    o_WRITE_DATA_A,
  output logic                       o_READ_ENABLE_B,
  output logic [p_ADDRESS_WIDTH-1:0] o_READ_ADDRESS_B,
  input  logic [p_DATA_WIDTH-1:0]    i_READ_DATA_B,
  output logic [p_ADDRESS_WIDTH+1:0] o_COUNT
);
  localparam int AW = p_ADDRESS_WIDTH;
  localparam int DW = p_DATA_WIDTH;
  localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_WPTR, r_RPTR;
  logic [AW:0]   r_MEM_WORDS;
  logic          r_INFLIGHT;
  logic [1:0]    r_OUT_COUNT;
  logic [DW-1:0] r_OUT_DATA0, r_OUT_DATA1;
  logic [AW+1:0] r_COUNT;

  logic          push, pop, issue, pop_valid, push_ready;
  logic [2:0]    occ;
  logic [1:0]    tail;
  logic [AW:0]   mem_nxt;
  logic [1:0]    out_nxt;
  logic [DW-1:0] data0_nxt, data1_nxt;

  assign push_ready = (r_MEM_WORDS < c_DEPTH);
  assign pop_valid  = (r_OUT_COUNT != 2'd0);
  assign push       = i_RESET_N & i_PUSH_VALID & push_ready;
  assign pop        = pop_valid & i_POP_READY;
  // Words in the output stage plus the one in flight, after this cycle's pop;
  // issuing only below 2 guarantees the capture always has a free slot.
  assign occ        = {1'b0, r_OUT_COUNT} + {2'b0, r_INFLIGHT} - {2'b0, pop};
  assign issue      = i_RESET_N & (r_MEM_WORDS != '0) & (occ < 3'd2);

  assign mem_nxt = r_MEM_WORDS + (AW+1)'(push) - (AW+1)'(issue);
  assign out_nxt = r_OUT_COUNT + {1'b0, r_INFLIGHT} - {1'b0, pop};
  assign tail    = r_OUT_COUNT - {1'b0, pop};

  always_comb begin
    data0_nxt = r_OUT_DATA0;
    data1_nxt = r_OUT_DATA1;
    if (pop) data0_nxt = r_OUT_DATA1;
    if (r_INFLIGHT) begin
      if (tail == 2'd0) data0_nxt = i_READ_DATA_B;
      else              data1_nxt = i_READ_DATA_B;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      r_WPTR      <= '0;
      r_RPTR      <= '0;
      r_MEM_WORDS <= '0;
      r_INFLIGHT  <= 1'b0;
      r_OUT_COUNT <= 2'd0;
      r_OUT_DATA0 <= '0;
      r_OUT_DATA1 <= '0;
      r_COUNT     <= '0;
    end else begin
      if (push)  r_WPTR <= r_WPTR + AW'(1);
      if (issue) r_RPTR <= r_RPTR + AW'(1);
      r_MEM_WORDS <= mem_nxt;
      r_INFLIGHT  <= issue;
      r_OUT_COUNT <= out_nxt;
      r_OUT_DATA0 <= data0_nxt;
      r_OUT_DATA1 <= data1_nxt;
      r_COUNT     <= {1'b0, mem_nxt} + (AW+2)'(issue) + (AW+2)'(out_nxt);
    end
  end

  assign o_PUSH_READY      = push_ready;
  assign o_POP_VALID       = pop_valid;
  assign o_POP_DATA        = pop_valid ? r_OUT_DATA0 : '0;
  assign o_WRITE_ENABLE_A  = push;
  assign o_WRITE_ADDRESS_A = r_WPTR;
  assign o_WRITE_DATA_A    = i_PUSH_DATA;
  assign o_READ_ENABLE_B   = issue;
  assign o_READ_ADDRESS_B  = r_RPTR;
  assign o_COUNT           = r_COUNT;
endmodule

// File: tb/tb_dual_port_bram_fifo_ctrl.sv
// Bench for dual_port_bram_fifo_ctrl with a behavioural BRAM and a queue scoreboard.
module tb_dual_port_bram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          i_CLK = 1'b0;
  logic          i_RESET_N = 1'b0;
  logic          i_PUSH_VALID = 1'b0;
  logic          o_PUSH_READY;
  logic [DW-1:0] i_PUSH_DATA = '0;
  logic          o_POP_VALID;
  logic          i_POP_READY = 1'b0;
  logic [DW-1:0] o_POP_DATA;
  logic          o_WRITE_ENABLE_A;
  logic [AW-1:0] o_WRITE_ADDRESS_A;
  logic [DW-1:0] o_WRITE_DATA_A;
  logic          o_READ_ENABLE_B;
  logic [AW-1:0] o_READ_ADDRESS_B;
  logic [DW-1:0] i_READ_DATA_B;
  logic [AW+1:0] o_COUNT;

  always #5 i_CLK = ~i_CLK;

  dual_port_bram_fifo_ctrl #(.p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
    .i_CLK(i_CLK), .i_RESET_N(i_RESET_N),
    .i_PUSH_VALID(i_PUSH_VALID), .o_PUSH_READY(o_PUSH_READY), .i_PUSH_DATA(i_PUSH_DATA),
    .o_POP_VALID(o_POP_VALID), .i_POP_READY(i_POP_READY), .o_POP_DATA(o_POP_DATA),
    .o_WRITE_ENABLE_A(o_WRITE_ENABLE_A), .o_WRITE_ADDRESS_A(o_WRITE_ADDRESS_A),
    .o_WRITE_DATA_A(o_WRITE_DATA_A), .o_READ_ENABLE_B(o_READ_ENABLE_B),
    .o_READ_ADDRESS_B(o_READ_ADDRESS_B), .i_READ_DATA_B(i_READ_DATA_B), .o_COUNT(o_COUNT)
  );

  // Behavioural BRAM: registered read, zero when not enabled.
  logic [DW-1:0] mem [2**AW];
  always @(posedge i_CLK) begin
    if (o_WRITE_ENABLE_A) mem[o_WRITE_ADDRESS_A] <= o_WRITE_DATA_A;
    i_READ_DATA_B <= o_READ_ENABLE_B ? mem[o_READ_ADDRESS_B] : '0;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] sb [$];

  logic          s_pr, s_pv, s_we, s_re;
  logic [DW-1:0] s_pd, s_wd;
  logic [AW-1:0] s_wa, s_ra;
  logic [AW+1:0] s_cnt;
  int first_pop_cyc, last_pop_cyc, n_pops;
  logic [DW-1:0] first_pop_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set (just after a falling edge).
  task automatic cycle();
    logic push_f, pop_f;
    #1;
    s_pr = o_PUSH_READY; s_pv = o_POP_VALID; s_pd = o_POP_DATA;
    s_we = o_WRITE_ENABLE_A; s_wa = o_WRITE_ADDRESS_A; s_wd = o_WRITE_DATA_A;
    s_re = o_READ_ENABLE_B; s_ra = o_READ_ADDRESS_B; s_cnt = o_COUNT;
    push_f = i_RESET_N & i_PUSH_VALID & s_pr;
    pop_f  = i_RESET_N & s_pv & i_POP_READY;
    if (!i_RESET_N) begin
      chk("rst_write_enable", 32'(s_we), 0);
      chk("rst_read_enable", 32'(s_re), 0);
    end else begin
      chk("count", 32'(s_cnt), sb.size());
      chk("write_enable", 32'(s_we), 32'(push_f));
      if (s_we) chk("write_data", 32'(s_wd), 32'(i_PUSH_DATA));
      if (s_pv) begin
        if (sb.size() == 0) chk("pop_valid_when_empty", 32'(s_pv), 0);
        else chk("pop_data", 32'(s_pd), 32'(sb[0]));
      end
      if (s_we && s_re) chk("addr_collision", 32'(s_wa == s_ra), 0);
    end
    @(posedge i_CLK);
    if (!i_RESET_N) sb.delete();
    else begin
      if (pop_f && sb.size() > 0) begin
        if (first_pop_cyc < 0) begin first_pop_cyc = cyc; first_pop_val = sb[0]; end
        last_pop_cyc = cyc;
        n_pops++;
        void'(sb.pop_front());
      end
      if (push_f) sb.push_back(i_PUSH_DATA);
    end
    cyc++;
    @(negedge i_CLK);
  endtask

  task automatic drain(input int bound);
    i_PUSH_VALID = 1'b0;
    i_POP_READY = 1'b1;
    for (int i = 0; i < bound && sb.size() > 0; i++) cycle();
    chk("drain_done", sb.size(), 0);
    i_POP_READY = 1'b0;
  endtask

  initial begin
    int acc, sent, rej, t0;
    logic [DW-1:0] val;
    first_pop_cyc = -1; last_pop_cyc = -1; n_pops = 0; first_pop_val = '0;
    @(negedge i_CLK);

    // Reset
    cycle(); cycle();
    i_RESET_N = 1'b1;
    cycle();
    chk("reset_pop_valid", 32'(s_pv), 0);
    chk("reset_count", 32'(s_cnt), 0);
    chk("reset_push_ready", 32'(s_pr), 1);
    chk("reset_read_enable", 32'(s_re), 0);
    chk("reset_pop_data", 32'(s_pd), 0);

    // Single word
    i_PUSH_VALID = 1'b1; i_PUSH_DATA = 8'hA5;
    cycle();
    chk("single_write_en", 32'(s_we), 1);
    chk("single_write_addr", 32'(s_wa), 0);
    i_PUSH_VALID = 1'b0;
    cycle();
    chk("single_read_en", 32'(s_re), 1);
    chk("single_read_addr", 32'(s_ra), 0);
    cycle();
    chk("single_not_yet_valid", 32'(s_pv), 0);
    i_POP_READY = 1'b1;
    cycle();
    chk("single_valid_t3", 32'(s_pv), 1);
    chk("single_data_t3", 32'(s_pd), 32'h A5);
    i_POP_READY = 1'b0;
    cycle();
    chk("single_count_zero", 32'(s_cnt), 0);

    // Fill
    acc = 0; val = 8'h01;
    i_PUSH_VALID = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i_PUSH_DATA = val;
      cycle();
      if (s_pr) begin acc++; val++; end
    end
    chk("fill_accepted", acc, 18);
    i_PUSH_VALID = 1'b0;
    cycle();
    chk("fill_ready_low", 32'(s_pr), 0);
    chk("fill_count", 32'(s_cnt), 18);
    n_pops = 0; first_pop_cyc = -1;
    i_POP_READY = 1'b1;
    cycle();
    chk("fill_ready_low_first_pop", 32'(s_pr), 0);
    cycle();
    chk("fill_ready_reassert", 32'(s_pr), 1);
    chk("fill_first_val", 32'(first_pop_val), 32'h01);
    drain(60);
    chk("fill_pops", n_pops, 18);

    // Streaming
    sent = 0; rej = 0; val = 8'h40; first_pop_cyc = -1; n_pops = 0;
    i_POP_READY = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 120 && (sent < 40 || sb.size() > 0); i++) begin
      i_PUSH_VALID = (sent < 40);
      i_PUSH_DATA = val;
      cycle();
      if (i_PUSH_VALID) begin
        if (s_pr) begin sent++; val++; end
        else rej++;
      end
    end
    chk("stream_sent", sent, 40);
    chk("stream_no_stall", rej, 0);
    chk("stream_pops", n_pops, 40);
    chk("stream_latency", first_pop_cyc - t0, 3);
    chk("stream_no_gaps", last_pop_cyc - first_pop_cyc, 39);
    chk("stream_empty", sb.size(), 0);

    // Random backpressure
    for (int i = 0; i < 500; i++) begin
      i_PUSH_VALID = 1'($urandom_range(0, 1));
      i_POP_READY  = 1'($urandom_range(0, 1));
      i_PUSH_DATA  = 8'($urandom);
      cycle();
    end
    drain(60);

    // Reset mid-operation
    i_POP_READY = 1'b0;
    i_PUSH_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_PUSH_DATA = 8'(8'h90 + i);
      cycle();
    end
    i_PUSH_VALID = 1'b0;
    cycle(); cycle(); cycle();
    chk("mid_count_before", 32'(s_cnt), 10);
    i_RESET_N = 1'b0;
    cycle();
    i_RESET_N = 1'b1;
    cycle();
    chk("mid_count_after", 32'(s_cnt), 0);
    chk("mid_pop_valid_after", 32'(s_pv), 0);
    i_PUSH_VALID = 1'b1; i_PUSH_DATA = 8'h77;
    cycle();
    first_pop_cyc = -1;
    drain(20);
    chk("mid_first_pop", 32'(first_pop_val), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
